// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Instruction prefetch unit with one outstanding memory request
//               and a DEPTH-entry {pc, instr} FIFO feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       mem_req,
   output logic [31:0]                mem_addr,
   input  logic                       mem_ack,
   input  logic [31:0]                mem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int               c_AW    = $clog2(DEPTH);
   localparam logic [c_AW:0]    c_DEPTH = (c_AW + 1)'(DEPTH);
   localparam logic [1:0]       c_IDLE  = 2'd0;
   localparam logic [1:0]       c_WAIT  = 2'd1;
   localparam logic [1:0]       c_DROP  = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_next;
   logic            r_mem_req;
   logic [31:0]     r_mem_addr;
   logic [31:0]     w_mem_addr_next;
   logic [31:0]     r_fetch_pc;
   logic [31:0]     w_fetch_pc_next;
   logic [31:0]     w_pc_inc;
   logic [31:0]     w_target;
   logic [c_AW:0]   r_count;
   logic [c_AW:0]   w_count_next;
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [31:0]     r_pc_mem    [DEPTH];
   logic [31:0]     r_instr_mem [DEPTH];
   logic            w_push;
   logic            w_pop;
   logic            w_issue;
   logic            w_unused_pc_lsbs;

   assign w_target         = {redirect_pc[31:2], 2'b00};
   assign w_unused_pc_lsbs = ^redirect_pc[1:0];
   assign w_pc_inc         = r_fetch_pc + 32'd4;
   assign w_count_next     = r_count + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_pop);
   // Issuing only while a slot stays free reserves room for the in-flight response.
   assign w_issue          = (w_count_next < c_DEPTH) && !redirect;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= RESET_PC;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_mem_req  <= (w_state_next != c_IDLE);
         r_mem_addr <= w_mem_addr_next;
         r_fetch_pc <= w_fetch_pc_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next    = r_state;
      w_mem_addr_next = r_mem_addr;
      w_fetch_pc_next = redirect ? w_target : r_fetch_pc;
      case (r_state)
         c_IDLE: begin
            if (redirect) begin
               w_state_next    = c_WAIT;
               w_mem_addr_next = w_target;
            end else if (w_issue) begin
               w_state_next    = c_WAIT;
               w_mem_addr_next = r_fetch_pc;
            end
         end
         c_WAIT: begin
            if (redirect) begin
               if (mem_ack) begin
                  w_state_next    = c_WAIT;
                  w_mem_addr_next = w_target;
               end else begin
                  w_state_next    = c_DROP;
               end
            end else if (mem_ack) begin
               w_fetch_pc_next = w_pc_inc;
               if (w_issue) begin
                  w_state_next    = c_WAIT;
                  w_mem_addr_next = w_pc_inc;
               end else begin
                  w_state_next    = c_IDLE;
               end
            end
         end
         c_DROP: begin
            // A stale response only releases the bus; fetch_pc is left alone.
            if (mem_ack) begin
               if (redirect) begin
                  w_state_next    = c_WAIT;
                  w_mem_addr_next = w_target;
               end else if (w_issue) begin
                  w_state_next    = c_WAIT;
                  w_mem_addr_next = r_fetch_pc;
               end else begin
                  w_state_next    = c_IDLE;
               end
            end
         end
         default: begin
            w_state_next = c_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      out_valid = (r_count != '0);
      w_push    = (r_state == c_WAIT) && mem_ack && !redirect;
      w_pop     = out_valid && out_ready && !redirect;
      out_pc    = r_pc_mem[r_rptr];
      out_instr = r_instr_mem[r_rptr];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else if (redirect) begin
         r_count <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
      end else begin
         if (w_push) begin
            r_pc_mem[r_wptr]    <= r_mem_addr;
            r_instr_mem[r_wptr] <= mem_rdata;
            r_wptr              <= r_wptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_AW'(1);
         end
         r_count <= w_count_next;
      end
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;
   assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Scoreboard bench for fetch_buffer with a latency-configurable
//               memory model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [2:0]  count;

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t exp_q[$];
   ent_t mon_e;

   int   lat = 0;
   int   cnt = 0;
   int   acks_done = 0;
   int   ack_limit = 0;
   logic force_ack = 1'b0;

   fetch_buffer #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .count       (count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
   endfunction

   // Memory model: ack after 'lat' waiting cycles, limited to a granted budget.
   assign mem_ack   = force_ack | (mem_req && (cnt >= lat) && (acks_done < ack_limit));
   assign mem_rdata = instr_of(mem_addr);

   always @(posedge clock) begin
      if (reset || !mem_req || mem_ack) cnt <= 0;
      else                              cnt <= cnt + 1;
      if (mem_req && mem_ack) acks_done <= acks_done + 1;
   end

   // Monitor
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready && !redirect) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected: got pc=%h instr=%h, required no entry", out_pc, out_instr);
         end else begin
            mon_e = exp_q.pop_front();
            if (out_pc !== mon_e.pc || out_instr !== mon_e.instr) begin
               n_bad++;
               $display("FAIL pop: got pc=%h instr=%h, required pc=%h instr=%h",
                        out_pc, out_instr, mon_e.pc, mon_e.instr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_pc(input logic [31:0] a);
      exp_q.push_back({a, instr_of(a)});
   endtask

   task automatic wait_addr(input logic [31:0] a);
      int k = 0;
      while (!(mem_req && mem_addr == a) && k < 50) begin
         tick();
         k++;
      end
      check("wait_addr", {31'd0, mem_req, mem_addr}, {32'd1, a});
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      redirect  = 1'b0;
      force_ack = 1'b0;
      tick();
      tick();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick(); tick(); tick();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);

      // Zero-wait streaming
      lat = 0; out_ready = 1'b1; ack_limit = acks_done + 4;
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
      reset = 1'b0;
      tick();
      check("first_req", mem_req, 1);
      for (int i = 0; i < 4; i++) begin
         check("stream_addr", mem_addr, 64'(4 * i));
         check("stream_count_le1", (count <= 3'd1), 1);
         tick();
      end
      repeat (3) tick();
      check("stream_drained", exp_q.size(), 0);
      check("stream_count_end", count, 0);

      // Backpressure fills the FIFO, then drains in order
      do_reset();
      lat = 0; out_ready = 1'b0; ack_limit = acks_done + 8;
      for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
      reset = 1'b0;
      repeat (6) tick();
      check("full_count", count, 4);
      check("full_mem_req", mem_req, 0);
      check("full_out_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      check("resume_req", mem_req, 1);
      check("resume_addr", mem_addr, 32'h10);
      repeat (12) tick();
      check("full_drained", exp_q.size(), 0);
      check("full_count_end", count, 0);

      // Two-cycle latency, redirect while 0x8 is outstanding
      do_reset();
      lat = 2; out_ready = 1'b1; ack_limit = acks_done + 5;
      expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h100); expect_pc(32'h104);
      reset = 1'b0;
      wait_addr(32'h8);
      tick();
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("drop_addr_held", {31'd0, mem_req, mem_addr}, {32'd1, 32'h8});
      check("drop_ack", mem_ack, 1);
      check("drop_count", count, 0);
      tick();
      check("drop_next_addr", mem_addr, 32'h100);
      repeat (12) tick();
      check("drop_drained", exp_q.size(), 0);

      // Redirect coinciding with ack and pop; low target bits ignored
      do_reset();
      lat = 0; out_ready = 1'b1; ack_limit = acks_done + 5;
      expect_pc(32'h0); expect_pc(32'h200); expect_pc(32'h204);
      reset = 1'b0;
      tick(); tick(); tick();
      check("coinc_pre_count", count, 1);
      check("coinc_pre_ack", mem_ack, 1);
      redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect = 1'b0;
      check("coinc_count", count, 0);
      check("coinc_out_valid", out_valid, 0);
      check("coinc_addr", {31'd0, mem_req, mem_addr}, {32'd1, 32'h200});
      repeat (8) tick();
      check("coinc_drained", exp_q.size(), 0);

      // Address wrap at 0xFFFF_FFFC
      do_reset();
      lat = 0; out_ready = 1'b1; ack_limit = acks_done;
      reset = 1'b0;
      tick();
      check("wrap_no_ack", mem_ack, 0);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
      ack_limit = acks_done + 3;
      check("wrap_drop_addr", mem_addr, 32'h0);
      tick();
      check("wrap_target", mem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_next", mem_addr, 32'h0);
      repeat (6) tick();
      check("wrap_drained", exp_q.size(), 0);

      // Reset mid-request, stray ack while idle
      do_reset();
      lat = 0; out_ready = 1'b1; ack_limit = acks_done;
      reset = 1'b0;
      tick();
      check("midrst_wait", mem_req, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0; force_ack = 1'b1;
      check("midrst_idle", mem_req, 0);
      tick();
      force_ack = 1'b0;
      check("midrst_count", count, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_addr", {31'd0, mem_req, mem_addr}, {32'd1, 32'h0});
      tick();
      check("midrst_count2", count, 0);
      check("midrst_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
